// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  // Wide enough to count ADDR_W or DUMMY_CYC sck rises (up to 63).
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  function automatic logic is_read_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_FAST_READ);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection on the
// last stage against one extra flop.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign w_level = r_sync[STAGES-1];
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/spi_flash_rsp.sv
// Single-bit SPI mode-0 flash responder serving READ/FAST_READ from a
// byte-wide synchronous memory; all pins are oversampled on clk.
module spi_flash_rsp
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_CYC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_W-1:0]      r_shift;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_fast;
  logic                   r_mem_req;
  logic                   r_req_d;
  logic [7:0]             r_tx;
  logic                   r_miso;
  logic                   r_oe;
  logic                   r_cmd_err;
  logic [ADDR_W-1:0]      w_shift_nxt;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (spi_sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  // cs_n synchronizer resets low, so a pin already low at reset release
  // produces no fall: a fresh rise then fall is needed to start a command.
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (spi_cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_shift_nxt = {r_shift[ADDR_W-2:0], w_mosi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_fast    <= 1'b0;
      r_mem_req <= 1'b0;
      r_req_d   <= 1'b0;
      r_tx      <= '0;
      r_miso    <= 1'b0;
      r_oe      <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_mem_req <= 1'b0;
      r_cmd_err <= 1'b0;
      r_req_d   <= r_mem_req;
      if (w_cs_rise) begin
        // Deselect wins over any coincident sck edge.
        r_state <= IDLE;
        r_cnt   <= '0;
        r_oe    <= 1'b0;
        r_miso  <= 1'b0;
        r_req_d <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cs_fall) begin
              r_state <= CMD;
              r_cnt   <= '0;
            end
          end
          CMD: begin
            if (w_sck_rise) begin
              r_shift <= w_shift_nxt;
              if (r_cnt == CNT_W'(7)) begin
                r_cnt <= '0;
                if (is_read_op(w_shift_nxt[7:0])) begin
                  r_fast  <= (w_shift_nxt[7:0] == OP_FAST_READ);
                  r_state <= ADDR;
                end else begin
                  r_cmd_err <= 1'b1;
                  r_state   <= IGNORE;
                end
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ADDR: begin
            if (w_sck_rise) begin
              r_shift <= w_shift_nxt;
              if (r_cnt == CNT_W'(ADDR_W - 1)) begin
                r_cnt  <= '0;
                r_addr <= w_shift_nxt;
                if (r_fast) begin
                  r_state <= DUMMY;
                end else begin
                  r_mem_req <= 1'b1;
                  r_state   <= DATA;
                end
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          DUMMY: begin
            if (w_sck_rise) begin
              if (r_cnt == CNT_W'(DUMMY_CYC - 1)) begin
                r_cnt     <= '0;
                r_mem_req <= 1'b1;
                r_state   <= DATA;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (w_sck_fall) begin
              r_oe   <= 1'b1;
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end
            // Fresh byte arrives one clk after the request; it overrides any shift.
            if (r_req_d) begin
              r_tx <= mem_rdata;
            end
            if (w_sck_rise) begin
              if (r_cnt == CNT_W'(7)) begin
                r_cnt     <= '0;
                r_addr    <= r_addr + ADDR_W'(1);
                r_mem_req <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          IGNORE: begin
            r_oe <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_addr;
  assign busy        = (r_state != IDLE);
  assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_spi_flash_rsp.sv
// Directed bench for spi_flash_rsp: an SPI initiator model plus scoreboard
// queues for expected MISO bytes and expected memory request addresses.
module tb_spi_flash_rsp;

  localparam int ADDR_W = 24;
  localparam int SYNC   = 2;
  localparam int DUMMY  = 8;
  localparam int HALF   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic              spi_sck = 1'b0;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata = 8'h00;
  logic              busy;
  logic              cmd_err;

  int checks = 0;
  int errors = 0;
  int cmd_err_cnt = 0;
  int oe_seen = 0;

  logic [7:0]        mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [7:0]        exp_byte_q[$];
  logic [ADDR_W-1:0] exp_a;

  always #5 clk = ~clk;

  spi_flash_rsp #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC),
    .DUMMY_CYC   (DUMMY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  function automatic logic [7:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5C;
  endfunction

  // Synchronous memory: data valid the clk after the request.
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= mem_rd(mem_addr);
  end

  // Request monitor: every mem_req must match the next expected address.
  always @(negedge clk) begin
    if (rst_n && mem_req) begin
      checks++;
      assert (exp_addr_q.size() != 0) else begin
        errors++;
        $error("FAIL mem_req_unexpected: got request at %06h, required no request", mem_addr);
      end
      if (exp_addr_q.size() != 0) begin
        exp_a = exp_addr_q.pop_front();
        checks++;
        assert (mem_addr === exp_a) else begin
          errors++;
          $error("FAIL mem_addr: got %06h, required %06h", mem_addr, exp_a);
        end
        $display("mem_req addr=%06h expected=%06h", mem_addr, exp_a);
      end
    end
    if (cmd_err) cmd_err_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer_bit(input logic mo, output logic mi);
    spi_mosi = mo;
    wait_clk(HALF);
    spi_sck = 1'b1;
    mi = spi_miso;
    if (spi_miso_oe) oe_seen++;
    wait_clk(HALF);
    spi_sck = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    logic d;
    for (int i = n - 1; i >= 0; i--) xfer_bit(v[i], d);
  endtask

  task automatic rx_check(input string tag);
    logic [7:0] b;
    logic [7:0] e;
    logic       d;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b0, d);
      b[i] = d;
    end
    e = exp_byte_q.pop_front();
    $display("%s miso byte=%02h expected=%02h", tag, b, e);
    chk(tag, {24'h0, b}, {24'h0, e});
    chk({tag, "_oe"}, {31'h0, spi_miso_oe}, 32'h1);
  endtask

  task automatic cs_low;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high;
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  initial begin
    wait_clk(3);
    chk("rst_outs", {27'h0, spi_miso, spi_miso_oe, mem_req, busy, cmd_err}, 32'h0);
    chk("rst_addr", {8'h0, mem_addr}, 32'h0);
    rst_n = 1'b1;
    wait_clk(4);

    // READ across a byte boundary, with prefetch of the third byte.
    mem[24'h000010] = 8'hA5;
    mem[24'h000011] = 8'h3C;
    exp_addr_q.push_back(24'h000010);
    exp_addr_q.push_back(24'h000011);
    exp_addr_q.push_back(24'h000012);
    exp_byte_q.push_back(8'hA5);
    exp_byte_q.push_back(8'h3C);
    cs_low();
    chk("t1_busy_cmd", {31'h0, busy}, 32'h1);
    oe_seen = 0;
    send(32'h03, 8);
    send(32'h000010, 24);
    chk("t1_oe_hdr", oe_seen, 0);
    rx_check("t1_byte0");
    rx_check("t1_byte1");
    cs_high();
    chk("t1_busy_end", {31'h0, busy}, 32'h0);
    chk("t1_oe_end", {30'h0, spi_miso_oe, spi_miso}, 32'h0);
    chk("t1_req_left", exp_addr_q.size(), 0);

    // FAST_READ with dummy cycles.
    mem[24'h000100] = 8'h5A;
    exp_addr_q.push_back(24'h000100);
    exp_addr_q.push_back(24'h000101);
    exp_byte_q.push_back(8'h5A);
    cs_low();
    oe_seen = 0;
    send(32'h0B, 8);
    send(32'h000100, 24);
    chk("t2_no_req_before_dummy", exp_addr_q.size(), 2);
    send(32'h0, DUMMY);
    chk("t2_oe_dummy", oe_seen, 0);
    rx_check("t2_byte0");
    cs_high();
    chk("t2_req_left", exp_addr_q.size(), 0);

    // Address wrap at the top of the space.
    mem[24'hFFFFFF] = 8'h11;
    mem[24'h000000] = 8'h22;
    exp_addr_q.push_back(24'hFFFFFF);
    exp_addr_q.push_back(24'h000000);
    exp_addr_q.push_back(24'h000001);
    exp_byte_q.push_back(8'h11);
    exp_byte_q.push_back(8'h22);
    cs_low();
    send(32'h03, 8);
    send(32'hFFFFFF, 24);
    rx_check("t3_byte0");
    rx_check("t3_byte1");
    cs_high();
    chk("t3_req_left", exp_addr_q.size(), 0);

    // Unsupported opcode.
    cmd_err_cnt = 0;
    oe_seen = 0;
    cs_low();
    send(32'h9F, 8);
    send($urandom, 32);
    chk("t4_cmd_err_pulses", cmd_err_cnt, 1);
    chk("t4_oe", oe_seen, 0);
    chk("t4_busy_held", {31'h0, busy}, 32'h1);
    cs_high();
    chk("t4_busy_end", {31'h0, busy}, 32'h0);

    // Abort after 13 address bits, then a normal READ.
    cs_low();
    send(32'h03, 8);
    send(32'h1ABC, 13);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(SYNC);
    chk("t5_busy_before_detect", {31'h0, busy}, 32'h1);
    wait_clk(1);
    chk("t5_busy_after_detect", {31'h0, busy}, 32'h0);
    wait_clk(HALF);
    mem[24'h000004] = 8'hC3;
    exp_addr_q.push_back(24'h000004);
    exp_addr_q.push_back(24'h000005);
    exp_byte_q.push_back(8'hC3);
    cs_low();
    send(32'h03, 8);
    send(32'h000004, 24);
    rx_check("t5_byte0");
    cs_high();
    chk("t5_req_left", exp_addr_q.size(), 0);

    // Reset during bit 3 of a data byte, released with cs_n still low.
    exp_addr_q.push_back(24'h000020);
    cs_low();
    send(32'h03, 8);
    send(32'h000020, 24);
    send(32'h0, 4);
    wait_clk(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {27'h0, spi_miso, spi_miso_oe, mem_req, busy, cmd_err}, 32'h0);
    chk("t6_rst_addr", {8'h0, mem_addr}, 32'h0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    oe_seen = 0;
    send(32'h03, 8);
    send(32'h000000, 24);
    send(32'h0, 8);
    chk("t6_oe_stale_cs", oe_seen, 0);
    chk("t6_busy_stale_cs", {31'h0, busy}, 32'h0);
    chk("t6_req_left", exp_addr_q.size(), 0);
    spi_cs_n = 1'b1;
    wait_clk(HALF);
    exp_addr_q.push_back(24'h000000);
    exp_addr_q.push_back(24'h000001);
    exp_byte_q.push_back(8'h22);
    cs_low();
    send(32'h03, 8);
    send(32'h000000, 24);
    rx_check("t6_byte0");
    cs_high();
    chk("t6_req_left_end", exp_addr_q.size(), 0);
    chk("cmd_err_total", cmd_err_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
